// File: rtl/fila_pkg.sv
// Shared definitions for the fila arbiter slice.
//   DATA_W      : element width of the shared fila
//   FILA_DEPTH  : fila capacity in elements
//   N_REQ       : requesters in round-robin order (P0, P1, C0, C1)
//   IDX_*       : requester indices; bit 1 set means consumer
//   arb_state_t : arbiter sequencing states
package fila_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FILA_DEPTH = 8;
  localparam int unsigned N_REQ      = 4;

  localparam logic [1:0] IDX_P0 = 2'd0;
  localparam logic [1:0] IDX_P1 = 2'd1;
  localparam logic [1:0] IDX_C0 = 2'd2;
  localparam logic [1:0] IDX_C1 = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    EXEC    = 3'd2,
    WAIT_RD = 3'd3,
    CAPTURE = 3'd4
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational 4-way round-robin selector.
//   eligible  : one bit per requester (P0, P1, C0, C1)
//   rr_ptr    : index where the search starts; wraps modulo 4
//   found     : some requester is eligible
//   grant_idx : first eligible index at or after rr_ptr
module rr_picker
  import fila_pkg::*;
(
  input  logic [N_REQ-1:0] eligible,
  input  logic [1:0]       rr_ptr,
  output logic             found,
  output logic [1:0]       grant_idx
);

  logic [1:0] w_idx;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    w_idx     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      // 2-bit add wraps the search naturally
      w_idx = rr_ptr + k[1:0];
      if (!found && eligible[w_idx]) begin
        found     = 1'b1;
        grant_idx = w_idx;
      end
    end
  end

endmodule

// File: rtl/fila_arbiter.sv
// Round-robin arbiter/sequencer sharing one fila between two producers and
// two consumers. Level req/ack handshakes in, single-cycle fila strobes out.
//   clock_10KHz   : system clock, rising edge
//   reset         : asynchronous active-low reset
//   wr_req/wr_data: producer requests and their data
//   rd_req        : consumer requests
//   wr_ack/rd_ack : one-cycle completion pulses
//   rd_data       : last dequeued value
//   busy          : an operation is in flight
//   q_*_out       : fila enqueue/dequeue strobes and write data
//   q_len_in      : fila occupancy
//   q_data_in     : fila read data
module fila_arbiter #(
  parameter int unsigned DATA_W     = fila_pkg::DATA_W,
  parameter int unsigned FILA_DEPTH = fila_pkg::FILA_DEPTH
) (
  input  logic                   clock_10KHz,
  input  logic                   reset,
  input  logic [1:0]             wr_req,
  input  logic [1:0][DATA_W-1:0] wr_data,
  input  logic [1:0]             rd_req,
  output logic [1:0]             wr_ack,
  output logic [1:0]             rd_ack,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   busy,
  output logic                   q_enqueue_out,
  output logic                   q_dequeue_out,
  output logic [DATA_W-1:0]      q_data_out,
  input  logic [7:0]             q_len_in,
  input  logic [DATA_W-1:0]      q_data_in
);

  import fila_pkg::*;

  localparam logic [7:0] LP_DEPTH = 8'(FILA_DEPTH);

  arb_state_t        r_state;
  logic [1:0]        r_rr_ptr;
  logic [1:0]        r_grant;
  logic [1:0]        r_wr_ack;
  logic [1:0]        r_rd_ack;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_q_data;
  logic              r_enq;
  logic              r_deq;

  logic              w_room;
  logic              w_avail;
  logic [N_REQ-1:0]  w_elig;
  logic              w_found;
  logic [1:0]        w_grant_idx;

  assign w_room  = (q_len_in < LP_DEPTH);
  assign w_avail = (q_len_in != '0);

  // A requester whose ack is high this cycle is still holding its old request
  assign w_elig[IDX_P0] = wr_req[0] & w_room  & ~r_wr_ack[0];
  assign w_elig[IDX_P1] = wr_req[1] & w_room  & ~r_wr_ack[1];
  assign w_elig[IDX_C0] = rd_req[0] & w_avail & ~r_rd_ack[0];
  assign w_elig[IDX_C1] = rd_req[1] & w_avail & ~r_rd_ack[1];

  rr_picker u_picker (
    .eligible  (w_elig),
    .rr_ptr    (r_rr_ptr),
    .found     (w_found),
    .grant_idx (w_grant_idx)
  );

  always_ff @(posedge clock_10KHz or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_grant   <= '0;
      r_wr_ack  <= '0;
      r_rd_ack  <= '0;
      r_rd_data <= '0;
      r_q_data  <= '0;
      r_enq     <= 1'b0;
      r_deq     <= 1'b0;
    end else begin
      r_wr_ack <= '0;
      r_rd_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant  <= w_grant_idx;
            r_rr_ptr <= w_grant_idx + 2'd1;
            r_state  <= ISSUE;
            // bit 1 of the index separates producers from consumers
            if (!w_grant_idx[1]) begin
              r_q_data <= wr_data[w_grant_idx[0]];
              r_enq    <= 1'b1;
            end else begin
              r_deq    <= 1'b1;
            end
          end
        end
        ISSUE: begin
          r_enq   <= 1'b0;
          r_deq   <= 1'b0;
          r_state <= EXEC;
        end
        EXEC: begin
          if (!r_grant[1]) begin
            r_wr_ack[r_grant[0]] <= 1'b1;
            r_state              <= IDLE;
          end else begin
            r_state <= WAIT_RD;
          end
        end
        WAIT_RD: r_state <= CAPTURE;
        CAPTURE: begin
          r_rd_data            <= q_data_in;
          r_rd_ack[r_grant[0]] <= 1'b1;
          r_state              <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wr_ack        = r_wr_ack;
  assign rd_ack        = r_rd_ack;
  assign rd_data       = r_rd_data;
  assign busy          = (r_state != IDLE);
  assign q_enqueue_out = r_enq;
  assign q_dequeue_out = r_deq;
  assign q_data_out    = r_q_data;

endmodule

// File: doc/fila_arbiter.md
Name: fila_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one fila (8-deep, 8-bit queue) between two producers and two consumers.
- Converts level request/ack handshakes into the single-cycle enqueue/dequeue pulses fila expects.
- Never issues an operation fila would ignore; a grant is always only to a full-legal operation.
- Sits directly in front of the fila instance; requesters never touch fila ports.

Parameters:
DATA_W, 8, data width; must match fila data width.
FILA_DEPTH, 8, fila capacity; producers are eligible only while q_len_in < FILA_DEPTH.

Ports:
clock_10KHz  input  1  system clock; all logic on its rising edge.
reset  input  1  asynchronous, active-low reset. The fila instance receives the inverted signal at top level.
wr_req  input  2  producer requests, index 0..1; level, held until the matching wr_ack.
wr_data  input  2xDATA_W  producer data (packed [1:0][DATA_W-1:0]); stable while wr_req is high.
rd_req  input  2  consumer requests, index 0..1; level, held until the matching rd_ack.
wr_ack  output  2  registered one-cycle pulse: the element is in fila.
rd_ack  output  2  registered one-cycle pulse: rd_data is valid.
rd_data  output  DATA_W  registered dequeued value; holds until the next dequeue completes.
busy  output  1  high whenever state != IDLE.
q_enqueue_out  output  1  to fila enqueue_in.
q_dequeue_out  output  1  to fila dequeue_in.
q_data_out  output  DATA_W  to fila data_in.
q_len_in  input  8  from fila len_out.
q_data_in  input  DATA_W  from fila data_out.

Behaviour:
- Reset (reset=0, async): state=IDLE and rr_ptr=0. All outputs are 0: wr_ack, rd_ack, rd_data, busy, q_enqueue_out, q_dequeue_out, q_data_out.
- Requester indices in round-robin order: 0=P0, 1=P1, 2=C0, 3=C1.
- Eligibility:
  - A producer is eligible when wr_req is set AND q_len_in < FILA_DEPTH AND its wr_ack is not high this cycle.
  - A consumer is eligible when rd_req is set AND q_len_in > 0 AND its rd_ack is not high this cycle.
- IDLE, cycle i:
  - Search starts at rr_ptr and wraps mod 4; the first eligible index g wins.
  - On a win: latch g; set rr_ptr <= (g+1) mod 4; go to ISSUE.
  - If g is a producer: q_data_out <= wr_data[g] and q_enqueue_out <= 1. Otherwise q_dequeue_out <= 1.
  - With no eligible index, stay in IDLE.
- ISSUE (i+1):
  - Exactly one of q_enqueue_out / q_dequeue_out is high, for this one cycle only. Both are never high together.
  - Clear both strobes at the edge; go to EXEC.
- EXEC (i+2):
  - fila is in its ENQUEUE/DEQUEUE state. q_data_out is held stable.
  - Enqueue: set wr_ack[g] <= 1 and go to IDLE.
  - Dequeue: go to WAIT_RD.
- WAIT_RD (i+3): fila loads its staging register; go to CAPTURE.
- CAPTURE (i+4):
  - q_data_in is valid in this cycle.
  - At the edge: rd_data <= q_data_in, rd_ack[g] <= 1; go to IDLE.
- Latency from the request sampled in IDLE cycle i:
  - wr_ack is high in cycle i+3 and q_len_in is already incremented in that cycle.
  - rd_ack is high in cycle i+5 and q_len_in is decremented from cycle i+3.
- Acks self-clear after one cycle.
- A requester still high in the ack cycle is masked, so it is not re-granted. A new request is assumed only from the following cycle.
- Full (q_len_in = FILA_DEPTH): producers wait and consumers are still served. Empty (q_len_in = 0): the reverse.
- Requests that are deasserted before the grant are dropped silently. Requests that are deasserted after the grant still complete and still get their ack.
- rr_ptr and the fila head/tail pointers wrap naturally; no special case.
- Reset in any state aborts the operation immediately, with no ack. fila is reset by the same event.

Decomposition:
- Package fila_pkg:
  - arb_state_t enum (IDLE, ISSUE, EXEC, WAIT_RD, CAPTURE; 3 bits).
  - Constants FILA_DEPTH=8, DATA_W=8, N_REQ=4.
  - Index constants IDX_P0..IDX_C1.
- One sub-module, rr_picker: combinational 4-way round-robin selector.
  - Inputs: eligible[3:0], rr_ptr[1:0].
  - Outputs: found, grant_idx[1:0].

Test Plan:
1. Single enqueue. len=0; P0 wr_req with wr_data=0x3C in cycle i. Required:
   - q_enqueue_out high only in i+1.
   - q_data_out=0x3C through i+2.
   - wr_ack[0] high in i+3; q_len_in=1.
2. Single dequeue, following test 1. C0 rd_req in cycle j. Required:
   - q_dequeue_out high only in j+1.
   - rd_ack[0] high in j+5 with rd_data=0x3C; q_len_in=0.
3. Round-robin. P0 (0xA0,0xA1,...) and P1 (0xB0,0xB1,...) request continuously. Required: grants alternate P0,P1,P0,P1; after 4 acks the fila contents in order are A0,B0,A1,B1.
4. Full. Fill to len=8, then P0 and C1 request together. Required:
   - C1 is granted and no q_enqueue_out is issued while len=8.
   - C1 receives the oldest element.
   - P0 is granted next, once len=7.
5. Empty. len=0 and C0 requests alone. Required:
   - busy and q_dequeue_out stay 0 for 20 cycles.
   - After P1 enqueues 0x55, C0 receives rd_data=0x55.
6. Reset mid-dequeue. Assert reset in WAIT_RD. Required:
   - All outputs are 0 immediately and state=IDLE.
   - No rd_ack is issued; rr_ptr=0 after release.
